// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module : fifo_pkg
// Brief  : Shared defaults and width helpers for the parametrised sync FIFO.
// Rev    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  // Default geometry, matching the fixed 8x16 FIFO this block replaces
  localparam int unsigned DEFAULT_WIDTH    = 8;
  localparam int unsigned DEFAULT_DEPTH    = 16;
  localparam int unsigned DEFAULT_AF_LEVEL = 12;
  localparam int unsigned DEFAULT_AE_LEVEL = 2;

  // Pointer width: enough bits to address DEPTH entries (at least 1)
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  // Occupancy width: one extra bit so the value DEPTH itself is representable
  function automatic int unsigned cnt_width(input int unsigned depth);
    return addr_width(depth) + 1;
  endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_mem_2p.sv
`default_nettype none
// ============================================================================
// Module : fifo_mem_2p
// Brief  : WIDTH x DEPTH storage, one write port and one registered read port.
//          Array contents are not reset; only the read register is.
// Rev    : 1.0 - initial release
// ============================================================================
module fifo_mem_2p
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned DEPTH  = DEFAULT_DEPTH,
  parameter int unsigned ADDR_W = addr_width(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port: plain RAM-style storage, no reset so it maps onto memory cells
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port: output register updates only on an accepted read, else holds
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : fifo_mem_2p
`default_nettype wire

// File: rtl/fifo_sync_param.sv
`default_nettype none
// ============================================================================
// Module : fifo_sync_param
// Brief  : Parametrised single-clock FIFO with concurrent read/write,
//          almost-full/almost-empty thresholds, synchronous flush and sticky
//          overflow/underflow error flags.
// Rev    : 1.0 - initial release
// ============================================================================
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned DEPTH    = DEFAULT_DEPTH,
  parameter int unsigned AF_LEVEL = DEFAULT_AF_LEVEL,
  parameter int unsigned AE_LEVEL = DEFAULT_AE_LEVEL,
  localparam int unsigned ADDR_W  = addr_width(DEPTH),
  localparam int unsigned CNT_W   = cnt_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] data_in_i,
  input  logic             rd_i,
  output logic [WIDTH-1:0] data_out_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             almost_empty_o,
  output logic             almost_full_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam logic [CNT_W-1:0]  C_DEPTH    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  C_AF_LEVEL = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0]  C_AE_LEVEL = CNT_W'(AE_LEVEL);
  localparam logic [ADDR_W-1:0] C_PTR_ONE  = ADDR_W'(1);

  // Pointer / occupancy state
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;

  // Status and sticky error flags, all registered from the next occupancy
  logic empty_q,    empty_d;
  logic full_q,     full_d;
  logic aempty_q,   aempty_d;
  logic afull_q,    afull_d;
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Access qualification
  logic rd_acc;
  logic wr_acc;
  logic mem_we;
  logic mem_re;

  // A read is only honoured with data present; a write into a full FIFO is
  // honoured when a read frees a slot on the same edge.
  always_comb begin
    rd_acc = rd_i & ~empty_q;
    wr_acc = wr_i & (~full_q | rd_acc);
    // Flush wins over any access, so memory and read register are left alone
    mem_we = wr_acc & ~clr_i;
    mem_re = rd_acc & ~clr_i;
  end

  // Next-state for pointers, occupancy, status and error flags
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    empty_d     = empty_q;
    full_d      = full_q;
    aempty_d    = aempty_q;
    afull_d     = afull_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (clr_i) begin
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      cnt_d       = '0;
      empty_d     = 1'b1;
      full_d      = 1'b0;
      aempty_d    = 1'b1;
      afull_d     = 1'b0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + C_PTR_ONE;
      end
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + C_PTR_ONE;
      end

      cnt_d = cnt_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);

      // Flags track cnt_d so they move on the same edge as the access
      empty_d  = (cnt_d == '0);
      full_d   = (cnt_d == C_DEPTH);
      aempty_d = (cnt_d <= C_AE_LEVEL);
      afull_d  = (cnt_d >= C_AF_LEVEL);

      // Refused requests only leave a sticky trace, nothing else changes
      overflow_d  = overflow_q  | (wr_i & ~wr_acc);
      underflow_d = underflow_q | (rd_i & ~rd_acc);
    end
  end

  // State register; reset puts the FIFO into the empty, error-free state
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      aempty_q    <= 1'b1;
      afull_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      aempty_q    <= aempty_d;
      afull_q     <= afull_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem_2p #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in_i),
    .re_i    (mem_re),
    .raddr_i (rd_ptr_q),
    .rdata_o (data_out_o)
  );

  assign empty_o        = empty_q;
  assign full_o         = full_q;
  assign almost_empty_o = aempty_q;
  assign almost_full_o  = afull_q;
  assign cnt_o          = cnt_q;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

endmodule : fifo_sync_param
`default_nettype wire

// File: tb/tb_fifo_sync_param.sv
`default_nettype none
// ============================================================================
// Module : tb_fifo_sync_param
// Brief  : Self-checking bench for fifo_sync_param (8x16, AF=12, AE=2) with a
//          queue-based reference model and directed plus random stimulus.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_fifo_sync_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 2;
  localparam int CW    = 5;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr   = 1'b0;
  logic             wr    = 1'b0;
  logic             rd    = 1'b0;
  logic [WIDTH-1:0] din   = '0;

  logic [WIDTH-1:0] dout;
  logic             empty, full, aempty, afull, ovf, udf;
  logic [CW-1:0]    cnt;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  fifo_sync_param #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .clr_i          (clr),
    .wr_i           (wr),
    .data_in_i      (din),
    .rd_i           (rd),
    .data_out_o     (dout),
    .empty_o        (empty),
    .full_o         (full),
    .almost_empty_o (aempty),
    .almost_full_o  (afull),
    .cnt_o          (cnt),
    .overflow_o     (ovf),
    .underflow_o    (udf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: an ordered queue of stored words plus sticky flags
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_dout = '0;
  bit               m_ovf  = 1'b0;
  bit               m_udf  = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    bit ra, wa;
    int sz;
    if (!rst_n) begin
      q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else if (clr) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      sz = q.size();
      ra = rd && (sz > 0);
      wa = wr && ((sz < DEPTH) || ra);
      if (ra) m_dout = q.pop_front();
      if (wa) q.push_back(din);
      if (wr && !wa) m_ovf = 1'b1;
      if (rd && !ra) m_udf = 1'b1;
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin : compare
    int sz;
    if (cmp_en) begin
      sz = q.size();
      check("cnt",          32'(cnt),    32'(sz));
      check("empty",        32'(empty),  32'(sz == 0));
      check("full",         32'(full),   32'(sz == DEPTH));
      check("almost_empty", 32'(aempty), 32'(sz <= AE));
      check("almost_full",  32'(afull),  32'(sz >= AF));
      check("overflow",     32'(ovf),    32'(m_ovf));
      check("underflow",    32'(udf),    32'(m_udf));
      check("data_out",     32'(dout),   32'(m_dout));
    end
  end

  // Drive one cycle's request; it takes effect at the following rising edge
  task automatic op(input bit w, input bit r, input logic [WIDTH-1:0] d, input bit c);
    @(negedge clk);
    wr  = w;
    rd  = r;
    din = d;
    clr = c;
  endtask

  // Idle cycle; on return the outputs reflect every previously issued op
  task automatic settle();
    op(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    wr = 1'b0; rd = 1'b0; clr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int pw, pr;
    // Power-on reset
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("reset cnt",    32'(cnt),    32'd0);
    check("reset empty",  32'(empty),  32'd1);
    check("reset full",   32'(full),   32'd0);
    check("reset aempty", 32'(aempty), 32'd1);
    check("reset afull",  32'(afull),  32'd0);
    check("reset dout",   32'(dout),   32'd0);
    check("reset ovf",    32'(ovf),    32'd0);
    check("reset udf",    32'(udf),    32'd0);
    cmp_en = 1'b1;

    // Fill with 0x01..0x10, then one write too many
    for (int i = 1; i <= 16; i++) begin
      op(1'b1, 1'b0, 8'(i), 1'b0);
      if (i == 12) check("afull after 11 writes", 32'(afull), 32'd0);
      if (i == 13) check("afull after 12 writes", 32'(afull), 32'd1);
    end
    op(1'b1, 1'b0, 8'h11, 1'b0);
    check("full after 16 writes", 32'(full), 32'd1);
    settle();
    check("overflow after 17th write", 32'(ovf), 32'd1);
    check("cnt after 17th write",      32'(cnt), 32'd16);

    // Drain in order, then one read too many
    for (int i = 1; i <= 16; i++) begin
      op(1'b0, 1'b1, '0, 1'b0);
      settle();
      check("drain order", 32'(dout), 32'(i));
    end
    check("empty after drain", 32'(empty), 32'd1);
    op(1'b0, 1'b1, '0, 1'b0);
    settle();
    check("underflow after 17th read", 32'(udf),  32'd1);
    check("dout holds after underflow", 32'(dout), 32'h10);

    // Pointer wrap
    op(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 10; i++) op(1'b1, 1'b0, 8'($urandom), 1'b0);
    for (int i = 0; i < 10; i++) op(1'b0, 1'b1, '0, 1'b0);
    for (int i = 0; i < 10; i++) op(1'b1, 1'b0, 8'(8'hA0 + i), 1'b0);
    for (int i = 0; i < 10; i++) begin
      op(1'b0, 1'b1, '0, 1'b0);
      settle();
      check("wrap order", 32'(dout), 32'(8'hA0 + i));
    end

    // Simultaneous read+write while full
    op(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 16; i++) op(1'b1, 1'b0, 8'(8'h20 + i), 1'b0);
    op(1'b1, 1'b1, 8'h55, 1'b0);
    settle();
    check("full rd&wr cnt",  32'(cnt),  32'd16);
    check("full rd&wr dout", 32'(dout), 32'h20);
    check("full rd&wr ovf",  32'(ovf),  32'd0);
    for (int i = 0; i < 16; i++) op(1'b0, 1'b1, '0, 1'b0);
    settle();
    check("0x55 read last", 32'(dout), 32'h55);

    // Simultaneous read+write while empty
    op(1'b1, 1'b1, 8'h66, 1'b0);
    settle();
    check("empty rd&wr cnt", 32'(cnt), 32'd1);
    check("empty rd&wr udf", 32'(udf), 32'd1);
    op(1'b0, 1'b1, '0, 1'b0);
    settle();
    check("empty rd&wr data", 32'(dout), 32'h66);

    // Flush with a pending write
    op(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 17; i++) op(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 9; i++)  op(1'b0, 1'b1, '0, 1'b0);
    settle();
    check("pre-flush cnt", 32'(cnt), 32'd7);
    check("pre-flush ovf", 32'(ovf), 32'd1);
    op(1'b1, 1'b0, 8'h77, 1'b1);
    settle();
    check("flush cnt",   32'(cnt),   32'd0);
    check("flush empty", 32'(empty), 32'd1);
    check("flush ovf",   32'(ovf),   32'd0);
    check("flush dout holds", 32'(dout), 32'h48);

    // Reset in the middle of traffic
    for (int i = 0; i < 5; i++) op(1'b1, 1'b0, 8'(8'h90 + i), 1'b0);
    op(1'b1, 1'b1, 8'h99, 1'b0);
    settle();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst cnt",    32'(cnt),    32'd0);
    check("midrst empty",  32'(empty),  32'd1);
    check("midrst full",   32'(full),   32'd0);
    check("midrst aempty", 32'(aempty), 32'd1);
    check("midrst dout",   32'(dout),   32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Randomised traffic with varying read/write pressure, flushes and resets
    for (int ph = 0; ph < 8; ph++) begin
      pw = $urandom_range(10, 90);
      pr = $urandom_range(10, 90);
      for (int c = 0; c < 500; c++) begin
        if ($urandom_range(0, 699) == 0) begin
          do_reset();
        end else begin
          op(($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < pr),
             8'($urandom), ($urandom_range(0, 99) == 0));
        end
      end
    end
    settle();
    settle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_fifo_sync_param
`default_nettype wire
